// File: rtl/checkpoint_rename_table.sv
// Speculative rename map with per-preg ready bits, committed map and a circular
// buffer of branch snapshots for single-cycle mispredict recovery.
module checkpoint_rename_table #(
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned WB_WIDTH     = 4,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned ARCH_REG_NUM = 32,
  parameter int unsigned PHY_REG_NUM  = 64,
  parameter int unsigned CKPT_NUM     = 4,
  localparam int unsigned PW = $clog2(PHY_REG_NUM),
  localparam int unsigned AW = $clog2(ARCH_REG_NUM),
  localparam int unsigned CW = $clog2(CKPT_NUM),
  localparam int unsigned SW = (DECODE_WIDTH > 1) ? $clog2(DECODE_WIDTH) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DECODE_WIDTH-1:0]               rename_valid_i,
  input  logic [DECODE_WIDTH-1:0]               dest_valid_i,
  input  logic [DECODE_WIDTH-1:0][AW-1:0]       src0_i,
  input  logic [DECODE_WIDTH-1:0][AW-1:0]       src1_i,
  input  logic [DECODE_WIDTH-1:0][AW-1:0]       dest_i,
  input  logic [DECODE_WIDTH-1:0][PW-1:0]       preg_i,
  output logic [DECODE_WIDTH-1:0][PW-1:0]       psrc0_o,
  output logic [DECODE_WIDTH-1:0][PW-1:0]       psrc1_o,
  output logic [DECODE_WIDTH-1:0]               psrc0_ready_o,
  output logic [DECODE_WIDTH-1:0]               psrc1_ready_o,
  output logic [DECODE_WIDTH-1:0][PW-1:0]       ppdst_o,
  input  logic [WB_WIDTH-1:0]                   wb_i,
  input  logic [WB_WIDTH-1:0][PW-1:0]           wb_pdest_i,
  input  logic                                  ckpt_alloc_i,
  input  logic [SW-1:0]                         ckpt_slot_i,
  output logic [CW-1:0]                         ckpt_id_o,
  output logic                                  ckpt_full_o,
  input  logic                                  ckpt_release_i,
  input  logic                                  restore_i,
  input  logic [CW-1:0]                         restore_id_i,
  input  logic [COMMIT_WIDTH-1:0]               commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0][AW-1:0]       commit_dest_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]       commit_preg_i,
  input  logic                                  flush_i
);

  localparam int unsigned CNTW = CW + 1;

  typedef logic [ARCH_REG_NUM-1:0][PW-1:0] map_t;

  function automatic map_t ident_map();
    map_t m;
    for (int a = 0; a < ARCH_REG_NUM; a++) m[a] = PW'(a);
    return m;
  endfunction

  localparam map_t ID_MAP = ident_map();

  map_t                    map_q, map_d, cmt_q, cmt_d;
  map_t                    ren_map, snap_map;
  map_t [CKPT_NUM-1:0]     snap_q;
  logic [PHY_REG_NUM-1:0]  ready_q, ready_d, wb_ready, ren_ready;
  logic [CW-1:0]           head_q, head_d, tail_q, tail_d, head_rel, live_cnt;
  logic [CNTW-1:0]         count_q, count_d;
  logic [DECODE_WIDTH-1:0] wr_en;
  logic                    alloc_ok, rel_ok, snap_we;

  assign ckpt_full_o = (count_q == CNTW'(CKPT_NUM));
  assign ckpt_id_o   = tail_q;

  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++)
      wr_en[i] = rename_valid_i[i] & dest_valid_i[i] & (dest_i[i] != '0);
  end

  // Source/dest lookup with youngest-earlier-slot bypass; r0 pinned to p0/ready
  always_comb begin
    psrc0_o       = '0;
    psrc1_o       = '0;
    psrc0_ready_o = '0;
    psrc1_ready_o = '0;
    ppdst_o       = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      psrc0_o[i]       = map_q[src0_i[i]];
      psrc0_ready_o[i] = ready_q[map_q[src0_i[i]]];
      psrc1_o[i]       = map_q[src1_i[i]];
      psrc1_ready_o[i] = ready_q[map_q[src1_i[i]]];
      ppdst_o[i]       = map_q[dest_i[i]];
      for (int j = 0; j < i; j++) begin
        if (wr_en[j]) begin
          if (dest_i[j] == src0_i[i]) begin
            psrc0_o[i]       = preg_i[j];
            psrc0_ready_o[i] = 1'b0;
          end
          if (dest_i[j] == src1_i[i]) begin
            psrc1_o[i]       = preg_i[j];
            psrc1_ready_o[i] = 1'b0;
          end
          if (dest_i[j] == dest_i[i]) ppdst_o[i] = preg_i[j];
        end
      end
      if (src0_i[i] == '0) begin
        psrc0_o[i]       = '0;
        psrc0_ready_o[i] = 1'b1;
      end
      if (src1_i[i] == '0) begin
        psrc1_o[i]       = '0;
        psrc1_ready_o[i] = 1'b1;
      end
      if (dest_i[i] == '0) ppdst_o[i] = '0;
    end
  end

  // Candidate tables: committed map, renamed map with branch snapshot, ready bits
  always_comb begin
    cmt_d     = cmt_q;
    ren_map   = map_q;
    snap_map  = map_q;
    wb_ready  = ready_q;
    for (int c = 0; c < COMMIT_WIDTH; c++)
      if (commit_valid_i[c] && (commit_dest_i[c] != '0)) cmt_d[commit_dest_i[c]] = commit_preg_i[c];
    for (int w = 0; w < WB_WIDTH; w++)
      if (wb_i[w]) wb_ready[wb_pdest_i[w]] = 1'b1;
    ren_ready = wb_ready;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (wr_en[i]) begin
        ren_map[dest_i[i]]   = preg_i[i];
        ren_ready[preg_i[i]] = 1'b0;
      end
      if (SW'(i) == ckpt_slot_i) snap_map = ren_map;
    end
  end

  // Next-state selection: flush > restore > rename/alloc
  always_comb begin
    alloc_ok = ckpt_alloc_i && !ckpt_full_o;
    rel_ok   = ckpt_release_i && (count_q != '0);
    head_rel = head_q + CW'(rel_ok);
    live_cnt = restore_id_i - head_rel;
    map_d    = ren_map;
    ready_d  = ren_ready;
    head_d   = head_rel;
    tail_d   = tail_q + CW'(alloc_ok);
    count_d  = count_q + CNTW'(alloc_ok) - CNTW'(rel_ok);
    snap_we  = alloc_ok;
    if (flush_i) begin
      map_d   = cmt_d;
      ready_d = '1;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      snap_we = 1'b0;
    end else if (restore_i) begin
      map_d   = snap_q[restore_id_i];
      ready_d = wb_ready;
      tail_d  = restore_id_i;
      count_d = CNTW'(live_cnt);
      snap_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q   <= ID_MAP;
      cmt_q   <= ID_MAP;
      ready_q <= '1;
      snap_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      map_q   <= map_d;
      cmt_q   <= cmt_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (snap_we) snap_q[tail_q] <= snap_map;
    end
  end

  a_no_alloc_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    (ckpt_alloc_i && !flush_i && !restore_i) |-> !ckpt_full_o);

endmodule

// File: tb/tb_checkpoint_rename_table.sv
// Randomized bench for checkpoint_rename_table against an array-based reference
// model, preceded by directed scenarios with hand-computed expectations.
module tb_checkpoint_rename_table;

  localparam int DW = 2, WBW = 4, CMW = 2, NA = 32, NP = 64, NC = 4;
  localparam int PW = 6, AW = 5, CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0]          rename_valid_i, dest_valid_i;
  logic [DW-1:0][AW-1:0]  src0_i, src1_i, dest_i;
  logic [DW-1:0][PW-1:0]  preg_i, psrc0_o, psrc1_o, ppdst_o;
  logic [DW-1:0]          psrc0_ready_o, psrc1_ready_o;
  logic [WBW-1:0]         wb_i;
  logic [WBW-1:0][PW-1:0] wb_pdest_i;
  logic                   ckpt_alloc_i, ckpt_full_o, ckpt_release_i, restore_i, flush_i;
  logic [0:0]             ckpt_slot_i;
  logic [CW-1:0]          ckpt_id_o, restore_id_i;
  logic [CMW-1:0]         commit_valid_i;
  logic [CMW-1:0][AW-1:0] commit_dest_i;
  logic [CMW-1:0][PW-1:0] commit_preg_i;

  checkpoint_rename_table dut (
    .clk(clk), .rst_n(rst_n),
    .rename_valid_i(rename_valid_i), .dest_valid_i(dest_valid_i),
    .src0_i(src0_i), .src1_i(src1_i), .dest_i(dest_i), .preg_i(preg_i),
    .psrc0_o(psrc0_o), .psrc1_o(psrc1_o),
    .psrc0_ready_o(psrc0_ready_o), .psrc1_ready_o(psrc1_ready_o), .ppdst_o(ppdst_o),
    .wb_i(wb_i), .wb_pdest_i(wb_pdest_i),
    .ckpt_alloc_i(ckpt_alloc_i), .ckpt_slot_i(ckpt_slot_i),
    .ckpt_id_o(ckpt_id_o), .ckpt_full_o(ckpt_full_o),
    .ckpt_release_i(ckpt_release_i), .restore_i(restore_i), .restore_id_i(restore_id_i),
    .commit_valid_i(commit_valid_i), .commit_dest_i(commit_dest_i),
    .commit_preg_i(commit_preg_i), .flush_i(flush_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: plain arrays; checkpoints as (head, count) over a ring of maps
  int m_map[NA];
  int m_cmt[NA];
  int m_snap[NC][NA];
  bit m_rdy[NP];
  int m_head, m_count;

  function automatic void model_reset();
    for (int a = 0; a < NA; a++) begin
      m_map[a] = a;
      m_cmt[a] = a;
    end
    for (int p = 0; p < NP; p++) m_rdy[p] = 1'b1;
    m_head  = 0;
    m_count = 0;
  endfunction

  function automatic bit slot_writes(input int j);
    return rename_valid_i[j] && dest_valid_i[j] && (dest_i[j] != 0);
  endfunction

  function automatic void m_lookup(input int i, input int a, output int p, output bit r);
    if (a == 0) begin
      p = 0;
      r = 1'b1;
      return;
    end
    p = m_map[a];
    r = m_rdy[p];
    for (int j = 0; j < i; j++)
      if (slot_writes(j) && int'(dest_i[j]) == a) begin
        p = int'(preg_i[j]);
        r = 1'b0;
      end
  endfunction

  function automatic void compare();
    int p;
    bit r;
    for (int i = 0; i < DW; i++) begin
      m_lookup(i, int'(src0_i[i]), p, r);
      chk($sformatf("psrc0[%0d]", i), 32'(psrc0_o[i]), p);
      chk($sformatf("psrc0_ready[%0d]", i), 32'(psrc0_ready_o[i]), 32'(r));
      m_lookup(i, int'(src1_i[i]), p, r);
      chk($sformatf("psrc1[%0d]", i), 32'(psrc1_o[i]), p);
      chk($sformatf("psrc1_ready[%0d]", i), 32'(psrc1_ready_o[i]), 32'(r));
      if (dest_i[i] == 0) p = 0;
      else m_lookup(i, int'(dest_i[i]), p, r);
      chk($sformatf("ppdst[%0d]", i), 32'(ppdst_o[i]), p);
    end
    chk("ckpt_full", 32'(ckpt_full_o), 32'(m_count == NC));
    chk("ckpt_id", 32'(ckpt_id_o), (m_head + m_count) % NC);
  endfunction

  function automatic void model_update();
    int ncmt[NA];
    int tmp[NA];
    int cap[NA];
    bit nrdy[NP];
    bit alloc_ok, rel_ok;
    int h;
    ncmt = m_cmt;
    for (int c = 0; c < CMW; c++)
      if (commit_valid_i[c] && commit_dest_i[c] != 0) ncmt[commit_dest_i[c]] = int'(commit_preg_i[c]);
    nrdy = m_rdy;
    for (int w = 0; w < WBW; w++)
      if (wb_i[w]) nrdy[wb_pdest_i[w]] = 1'b1;
    alloc_ok = ckpt_alloc_i && (m_count < NC);
    rel_ok   = ckpt_release_i && (m_count > 0);
    if (flush_i) begin
      m_map = ncmt;
      for (int p = 0; p < NP; p++) m_rdy[p] = 1'b1;
      m_head  = 0;
      m_count = 0;
    end else if (restore_i) begin
      h       = (m_head + int'(rel_ok)) % NC;
      m_map   = m_snap[restore_id_i];
      m_rdy   = nrdy;
      m_head  = h;
      m_count = ((int'(restore_id_i) - h) % NC + NC) % NC;
    end else begin
      tmp = m_map;
      cap = m_map;
      for (int i = 0; i < DW; i++) begin
        if (slot_writes(i)) begin
          tmp[dest_i[i]]  = int'(preg_i[i]);
          nrdy[preg_i[i]] = 1'b0;
        end
        if (i == int'(ckpt_slot_i)) cap = tmp;
      end
      if (alloc_ok) m_snap[(m_head + m_count) % NC] = cap;
      m_map   = tmp;
      m_rdy   = nrdy;
      m_count = m_count + int'(alloc_ok) - int'(rel_ok);
      m_head  = (m_head + int'(rel_ok)) % NC;
    end
    m_cmt = ncmt;
  endfunction

  task automatic idle();
    rename_valid_i = '0; dest_valid_i = '0;
    src0_i = '0; src1_i = '0; dest_i = '0; preg_i = '0;
    wb_i = '0; wb_pdest_i = '0;
    ckpt_alloc_i = 1'b0; ckpt_slot_i = '0; ckpt_release_i = 1'b0;
    restore_i = 1'b0; restore_id_i = '0;
    commit_valid_i = '0; commit_dest_i = '0; commit_preg_i = '0;
    flush_i = 1'b0;
  endtask

  // Inputs are driven just after a falling edge; outputs are checked 1ns later
  task automatic tick();
    #1;
    compare();
    model_update();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic ren(input int slot, input int d, input int p);
    rename_valid_i[slot] = 1'b1;
    dest_valid_i[slot]   = 1'b1;
    dest_i[slot]         = AW'(d);
    preg_i[slot]         = PW'(p);
  endtask

  task automatic look(input int a, output int p, output bit r);
    src0_i[0] = AW'(a);
    #1;
    p = int'(psrc0_o[0]);
    r = psrc0_ready_o[0];
  endtask

  int p;
  bit r;

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    look(5, p, r);
    chk("reset_map_r5", p, 5);
    chk("reset_ready_r5", 32'(r), 1);
    chk("reset_full", 32'(ckpt_full_o), 0);
    chk("reset_id", 32'(ckpt_id_o), 0);
    tick();

    ren(0, 5, 40);
    tick();
    look(5, p, r);
    chk("r5_to_p40", p, 40);
    chk("p40_not_ready", 32'(r), 0);
    wb_i[0] = 1'b1; wb_pdest_i[0] = 6'd40;
    tick();
    look(5, p, r);
    chk("p40_ready_after_wb", 32'(r), 1);
    tick();

    ren(0, 3, 33); ren(1, 3, 34); src0_i[1] = 5'd3;
    #1;
    chk("bypass_psrc0", 32'(psrc0_o[1]), 33);
    chk("bypass_ready", 32'(psrc0_ready_o[1]), 0);
    chk("bypass_ppdst", 32'(ppdst_o[1]), 33);
    tick();
    look(3, p, r);
    chk("waw_r3", p, 34);
    tick();

    ren(0, 7, 50); ren(1, 7, 51); ckpt_alloc_i = 1'b1; ckpt_slot_i = 1'b0;
    #1;
    chk("alloc_id0", 32'(ckpt_id_o), 0);
    tick();
    look(7, p, r);
    chk("r7_spec_51", p, 51);
    restore_i = 1'b1; restore_id_i = 2'd0;
    tick();
    look(7, p, r);
    chk("r7_restored_50", p, 50);
    chk("restore0_full", 32'(ckpt_full_o), 0);
    chk("restore0_id", 32'(ckpt_id_o), 0);
    tick();

    repeat (4) begin
      ckpt_alloc_i = 1'b1;
      tick();
    end
    #1;
    chk("full_after_4", 32'(ckpt_full_o), 1);
    ckpt_release_i = 1'b1;
    tick();
    #1;
    chk("release_not_full", 32'(ckpt_full_o), 0);
    chk("release_id", 32'(ckpt_id_o), 0);
    restore_i = 1'b1; restore_id_i = 2'd2;
    tick();
    #1;
    chk("restore2_tail", 32'(ckpt_id_o), 2);
    chk("restore2_full", 32'(ckpt_full_o), 0);
    repeat (3) begin
      ckpt_alloc_i = 1'b1;
      tick();
    end
    #1;
    chk("restore2_count1_refill", 32'(ckpt_full_o), 1);

    commit_valid_i[0] = 1'b1; commit_dest_i[0] = 5'd4; commit_preg_i[0] = 6'd45;
    tick();
    ren(0, 4, 46);
    tick();
    look(4, p, r);
    chk("r4_spec_46", p, 46);
    flush_i = 1'b1;
    tick();
    look(4, p, r);
    chk("flush_r4_45", p, 45);
    chk("flush_ready", 32'(r), 1);
    chk("flush_full", 32'(ckpt_full_o), 0);
    chk("flush_id", 32'(ckpt_id_o), 0);
    tick();

    ren(0, 9, 20);
    tick();
    ckpt_alloc_i = 1'b1;
    tick();
    ren(0, 9, 21); flush_i = 1'b1; restore_i = 1'b1; restore_id_i = 2'd0;
    tick();
    look(9, p, r);
    chk("flush_beats_restore", p, 9);
    tick();

    ren(0, 0, 22); src0_i[1] = 5'd0;
    #1;
    chk("r0_ppdst", 32'(ppdst_o[0]), 0);
    chk("r0_psrc", 32'(psrc0_o[1]), 0);
    chk("r0_ready", 32'(psrc0_ready_o[1]), 1);
    tick();
    look(0, p, r);
    chk("r0_unchanged", p, 0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        ren(0, 7, 60);
        rst_n = 1'b0;
        idle();
        look(7, p, r);
        chk("async_reset_r7", p, 7);
        chk("async_reset_ready", 32'(r), 1);
        chk("async_reset_full", 32'(ckpt_full_o), 0);
        model_reset();
        #1;
        rst_n = 1'b1;
      end
      for (int i = 0; i < DW; i++) begin
        rename_valid_i[i] = ($urandom_range(0, 3) != 0);
        dest_valid_i[i]   = ($urandom_range(0, 3) != 0);
        src0_i[i] = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NA - 1));
        src1_i[i] = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NA - 1));
        dest_i[i] = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NA - 1));
        preg_i[i] = PW'($urandom_range(1, NP - 1));
      end
      for (int w = 0; w < WBW; w++) begin
        wb_i[w]       = ($urandom_range(0, 9) < 4);
        wb_pdest_i[w] = PW'($urandom_range(0, NP - 1));
      end
      for (int c = 0; c < CMW; c++) begin
        commit_valid_i[c] = ($urandom_range(0, 3) == 0);
        commit_dest_i[c]  = AW'($urandom_range(0, NA - 1));
        commit_preg_i[c]  = PW'($urandom_range(1, NP - 1));
      end
      ckpt_slot_i    = 1'($urandom_range(0, 1));
      ckpt_alloc_i   = ($urandom_range(0, 99) < 25) && (m_count < NC);
      ckpt_release_i = ($urandom_range(0, 99) < 20) && (m_count > 0);
      if (m_count > 0 && $urandom_range(0, 99) < 6) begin
        if (ckpt_release_i && m_count < 2) ckpt_release_i = 1'b0;
        restore_i    = 1'b1;
        restore_id_i = CW'((m_head + $urandom_range(ckpt_release_i ? 1 : 0, m_count - 1)) % NC);
      end
      flush_i = ($urandom_range(0, 99) < 2);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
